parity_serial_tx: RTL and testbench



---
 rtl/parity_pkg.sv | 14 +
 rtl/parity_gen.sv | 14 +
 rtl/parity_serial_tx.sv | 121 ++++++++++++
 tb/tb_parity_serial_tx.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared types and constants for the parity serial transmitter
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } tx_state_t;

    localparam int PARITY_EVEN     = 0;
    localparam int PARITY_ODD_MODE = 1;
    localparam int DEFAULT_DATA_W  = 8;

endpackage

// File: rtl/parity_gen.sv
// rtl/parity_gen.sv - reduction-XOR parity over a data word, with even/odd mode select
module parity_gen
    import parity_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic              odd_i,
    output logic              parity_o
);

    assign parity_o = (^data_i) ^ odd_i;

endmodule

// File: rtl/parity_serial_tx.sv
// rtl/parity_serial_tx.sv - LSB-first serialiser that appends a parity bit to each accepted word
module parity_serial_tx
    import parity_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int PARITY_ODD = PARITY_EVEN,
    parameter int COUNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  data_in,
    input  logic               data_valid,
    output logic               data_ready,
    input  logic               inject_err,
    output logic               tx_bit,
    output logic               tx_valid,
    output logic               tx_last,
    output logic               busy,
    output logic [COUNT_W-1:0] frame_count
);

    localparam int                   BIT_CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(DATA_W - 1);
    localparam logic                 MODE_ODD  = (PARITY_ODD == PARITY_ODD_MODE);

    tx_state_t              state_q, state_d;
    logic [DATA_W-1:0]      shreg_q, shreg_d;
    logic                   par_q, par_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [COUNT_W-1:0]     frame_cnt_q, frame_cnt_d;
    logic                   accept;
    logic                   gen_par;

    // Ready in PARITY as well as IDLE so the next frame follows with no gap.
    assign data_ready = !rst && (state_q == IDLE || state_q == PARITY);
    assign accept     = data_valid && data_ready;

    parity_gen #(
        .DATA_W (DATA_W)
    ) u_parity_gen (
        .data_i   (data_in),
        .odd_i    (MODE_ODD),
        .parity_o (gen_par)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SHIFT;
            SHIFT:   if (bit_cnt_q == LAST_BIT) state_d = PARITY;
            PARITY:  state_d = accept ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        tx_bit   = 1'b0;
        busy     = 1'b0;
        case (state_q)
            SHIFT: begin
                tx_valid = 1'b1;
                tx_bit   = shreg_q[0];
                busy     = 1'b1;
            end
            PARITY: begin
                tx_valid = 1'b1;
                tx_last  = 1'b1;
                tx_bit   = par_q;
                busy     = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        shreg_d     = shreg_q;
        par_d       = par_q;
        bit_cnt_d   = bit_cnt_q;
        frame_cnt_d = frame_cnt_q;
        if (state_q == SHIFT) begin
            shreg_d   = shreg_q >> 1;
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        end
        if (state_q == PARITY) begin
            frame_cnt_d = frame_cnt_q + COUNT_W'(1);
        end
        // Accept never coincides with SHIFT, so it cleanly overrides the shift path.
        if (accept) begin
            shreg_d   = data_in;
            par_d     = gen_par ^ inject_err;
            bit_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q     <= '0;
            par_q       <= 1'b0;
            bit_cnt_q   <= '0;
            frame_cnt_q <= '0;
        end else begin
            shreg_q     <= shreg_d;
            par_q       <= par_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_count = frame_cnt_q;

endmodule

// File: tb/tb_parity_serial_tx.sv
// tb/tb_parity_serial_tx.sv - self-checking bench for parity_serial_tx (even, odd and 4-bit counter instances)
module tb_parity_serial_tx;

    localparam int NI = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       inject_err = 1'b0;

    logic        rdy   [NI];
    logic        tbit  [NI];
    logic        tval  [NI];
    logic        tlast [NI];
    logic        bsy   [NI];
    logic [15:0] fc_e, fc_o;
    logic [3:0]  fc_4;

    always #5 clk = ~clk;

    parity_serial_tx u_even (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid), .data_ready(rdy[0]),
        .inject_err(inject_err), .tx_bit(tbit[0]), .tx_valid(tval[0]), .tx_last(tlast[0]),
        .busy(bsy[0]), .frame_count(fc_e)
    );

    parity_serial_tx #(.PARITY_ODD(1)) u_odd (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid), .data_ready(rdy[1]),
        .inject_err(inject_err), .tx_bit(tbit[1]), .tx_valid(tval[1]), .tx_last(tlast[1]),
        .busy(bsy[1]), .frame_count(fc_o)
    );

    parity_serial_tx #(.COUNT_W(4)) u_cw4 (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid), .data_ready(rdy[2]),
        .inject_err(inject_err), .tx_bit(tbit[2]), .tx_valid(tval[2]), .tx_last(tlast[2]),
        .busy(bsy[2]), .frame_count(fc_4)
    );

    int passed = 0;
    int total  = 0;
    int fc_model = 0;

    typedef struct packed {
        logic [7:0] w;
        logic       inj;
    } exp_t;

    exp_t eq0[$], eq1[$], eq2[$];

    logic [8:0] cur_bits  [NI];
    int         cur_n     [NI];
    logic [8:0] last_bits [NI];
    logic [8:0] prev_bits [NI];
    logic       last_err  [NI];
    int         rx_cnt    [NI];
    int         aborts    [NI];
    int         run = 0, max_run = 0, ready_viol = 0;

    exp_t mon_e;
    logic mon_have;
    int   mon_mode, mon_ep, mon_got_err;

    // Scoreboard: every completed frame is compared with the word the bench handed over.
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (tval[k]) begin
                if (cur_n[k] < 9) cur_bits[k][cur_n[k]] = tbit[k];
                cur_n[k]++;
                if (tlast[k]) begin
                    mon_have = 1'b0;
                    case (k)
                        0: if (eq0.size() > 0) begin mon_e = eq0.pop_front(); mon_have = 1'b1; end
                        1: if (eq1.size() > 0) begin mon_e = eq1.pop_front(); mon_have = 1'b1; end
                        default: if (eq2.size() > 0) begin mon_e = eq2.pop_front(); mon_have = 1'b1; end
                    endcase
                    mon_mode = (k == 1) ? 1 : 0;
                    mon_got_err = (($countones(cur_bits[k]) + mon_mode) % 2 != 0) ? 1 : 0;
                    total++;
                    if (!mon_have) $display("FAIL frame_expected inst=%0d got=unexpected frame %h want=none", k, cur_bits[k]);
                    else passed++;
                    if (mon_have) begin
                        mon_ep = ($countones(mon_e.w) + mon_mode + int'(mon_e.inj)) % 2;
                        total++;
                        if (cur_n[k] != 9) $display("FAIL frame_len inst=%0d got=%0d want=9", k, cur_n[k]);
                        else passed++;
                        total++;
                        if (cur_bits[k][7:0] !== mon_e.w) $display("FAIL frame_data inst=%0d got=%h want=%h", k, cur_bits[k][7:0], mon_e.w);
                        else passed++;
                        total++;
                        if (int'(cur_bits[k][8]) != mon_ep) $display("FAIL frame_parity inst=%0d word=%h got=%0d want=%0d", k, mon_e.w, cur_bits[k][8], mon_ep);
                        else passed++;
                        total++;
                        if (mon_got_err != int'(mon_e.inj)) $display("FAIL rx_check inst=%0d got=%0d want=%0d", k, mon_got_err, mon_e.inj);
                        else passed++;
                    end
                    prev_bits[k] = last_bits[k];
                    last_bits[k] = cur_bits[k];
                    last_err[k]  = mon_got_err[0];
                    rx_cnt[k]++;
                    cur_n[k]    = 0;
                    cur_bits[k] = '0;
                end
            end else if (cur_n[k] != 0) begin
                aborts[k]++;
                cur_n[k]    = 0;
                cur_bits[k] = '0;
            end
        end
        if (tval[0]) begin
            run++;
            if (rdy[0] !== tlast[0]) ready_viol++;
        end else begin
            run = 0;
        end
        if (run > max_run) max_run = run;
    end

    task automatic push(input logic [7:0] w, input logic inj);
        int t = 0;
        @(negedge clk);
        data_in    = w;
        inject_err = inj;
        data_valid = 1'b1;
        while (!rdy[0] && t < 100) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (t >= 100) $display("FAIL accept_timeout got=%0d cycles want<100 word=%h", t, w);
        else passed++;
        @(posedge clk);
        eq0.push_back('{w: w, inj: inj});
        eq1.push_back('{w: w, inj: inj});
        eq2.push_back('{w: w, inj: inj});
        fc_model++;
        #1;
    endtask

    task automatic release_in(input int gap);
        @(negedge clk);
        data_valid = 1'b0;
        data_in    = 8'($urandom_range(255, 0));
        inject_err = 1'($urandom_range(1, 0));
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while ((bsy[0] || tval[0]) && t < 200) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (t >= 200) $display("FAIL idle_timeout got=%0d cycles want<200", t);
        else passed++;
    endtask

    task automatic clear_model();
        eq0.delete();
        eq1.delete();
        eq2.delete();
        fc_model = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            total++;
            if ({tbit[k], tval[k], tlast[k], bsy[k], rdy[k]} !== 5'b00000)
                $display("FAIL reset_outputs inst=%0d got=%b want=00000", k, {tbit[k], tval[k], tlast[k], bsy[k], rdy[k]});
            else passed++;
        end
        total++;
        if (fc_e !== 16'd0 || fc_o !== 16'd0 || fc_4 !== 4'd0)
            $display("FAIL reset_count got=%h/%h/%h want=0", fc_e, fc_o, fc_4);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if ({rdy[0], rdy[1], rdy[2]} !== 3'b111) $display("FAIL ready_after_reset got=%b want=111", {rdy[0], rdy[1], rdy[2]});
        else passed++;
        clear_model();
    endtask

    task automatic test_basic_even();
        push(8'hA5, 1'b0);
        release_in(0);
        wait_idle();
        total++;
        if (last_bits[0] !== 9'h0A5) $display("FAIL a5_even got=%h want=0a5", last_bits[0]);
        else passed++;
        total++;
        if (last_bits[1] !== 9'h1A5) $display("FAIL a5_odd got=%h want=1a5", last_bits[1]);
        else passed++;
        total++;
        if (fc_e !== 16'(fc_model) || fc_4 !== 4'(fc_model)) $display("FAIL a5_count got=%0d/%0d want=%0d", fc_e, fc_4, fc_model);
        else passed++;
    endtask

    task automatic test_parity_modes();
        push(8'h07, 1'b0);
        release_in(1);
        wait_idle();
        total++;
        if (last_bits[0] !== 9'h107) $display("FAIL w07_even got=%h want=107", last_bits[0]);
        else passed++;
        total++;
        if (last_bits[1] !== 9'h007) $display("FAIL w07_odd got=%h want=007", last_bits[1]);
        else passed++;
    endtask

    task automatic test_inject();
        push(8'h00, 1'b1);
        release_in(0);
        wait_idle();
        total++;
        if (last_bits[0] !== 9'h100 || last_err[0] !== 1'b1) $display("FAIL inject_even got=%h err=%b want=100 err=1", last_bits[0], last_err[0]);
        else passed++;
        total++;
        if (last_bits[1] !== 9'h000 || last_err[1] !== 1'b1) $display("FAIL inject_odd got=%h err=%b want=000 err=1", last_bits[1], last_err[1]);
        else passed++;
        push(8'h00, 1'b0);
        release_in(0);
        wait_idle();
        total++;
        if (last_bits[0] !== 9'h000 || last_err[0] !== 1'b0) $display("FAIL clean_zero got=%h err=%b want=000 err=0", last_bits[0], last_err[0]);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int rx0;
        rx0 = rx_cnt[0];
        max_run    = 0;
        ready_viol = 0;
        push(8'h01, 1'b0);
        push(8'h03, 1'b0);
        release_in(0);
        wait_idle();
        total++;
        if (max_run != 18) $display("FAIL b2b_valid_run got=%0d want=18", max_run);
        else passed++;
        total++;
        if (ready_viol != 0) $display("FAIL b2b_ready_in_shift got=%0d want=0", ready_viol);
        else passed++;
        total++;
        if (prev_bits[0] !== 9'h101 || last_bits[0] !== 9'h003) $display("FAIL b2b_frames got=%h,%h want=101,003", prev_bits[0], last_bits[0]);
        else passed++;
        total++;
        if (rx_cnt[0] - rx0 != 2) $display("FAIL b2b_frame_total got=%0d want=2", rx_cnt[0] - rx0);
        else passed++;
        total++;
        if (fc_e !== 16'(fc_model)) $display("FAIL b2b_count got=%0d want=%0d", fc_e, fc_model);
        else passed++;
    endtask

    task automatic test_reset_midframe();
        int ab0;
        ab0 = aborts[0];
        push(8'hFF, 1'b0);
        data_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            total++;
            if ({tval[k], tlast[k], bsy[k], rdy[k]} !== 4'b0000)
                $display("FAIL midreset_outputs inst=%0d got=%b want=0000", k, {tval[k], tlast[k], bsy[k], rdy[k]});
            else passed++;
        end
        total++;
        if (fc_e !== 16'd0 || fc_4 !== 4'd0) $display("FAIL midreset_count got=%0d/%0d want=0", fc_e, fc_4);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (rdy[0] !== 1'b1) $display("FAIL midreset_ready got=%b want=1", rdy[0]);
        else passed++;
        total++;
        if (aborts[0] - ab0 != 1) $display("FAIL midreset_abort got=%0d want=1", aborts[0] - ab0);
        else passed++;
        clear_model();
        push(8'h0F, 1'b0);
        release_in(0);
        wait_idle();
        total++;
        if (last_bits[0] !== 9'h00F || last_bits[1] !== 9'h10F) $display("FAIL fresh_0f got=%h/%h want=00f/10f", last_bits[0], last_bits[1]);
        else passed++;
        total++;
        if (fc_e !== 16'd1) $display("FAIL fresh_count got=%0d want=1", fc_e);
        else passed++;
    endtask

    task automatic test_wrap_random();
        int rx0;
        @(negedge clk);
        rst = 1'b1;
        data_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        rx0 = rx_cnt[0];
        for (int i = 0; i < 17; i++) begin
            push(8'($urandom_range(255, 0)), 1'($urandom_range(1, 0)));
            if (i >= 15 || $urandom_range(1, 0) == 1) begin
                release_in($urandom_range(3, 0));
                wait_idle();
            end
            if (i == 15) begin
                total++;
                if (fc_4 !== 4'd0 || fc_e !== 16'd16) $display("FAIL wrap_at_16 got=%0d/%0d want=0/16", fc_4, fc_e);
                else passed++;
            end
        end
        total++;
        if (fc_4 !== 4'd1 || fc_e !== 16'd17) $display("FAIL wrap_at_17 got=%0d/%0d want=1/17", fc_4, fc_e);
        else passed++;
        total++;
        if (rx_cnt[0] - rx0 != 17 || eq0.size() != 0) $display("FAIL wrap_frames got=%0d pending=%0d want=17 pending=0", rx_cnt[0] - rx0, eq0.size());
        else passed++;
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            cur_bits[k]  = '0;
            cur_n[k]     = 0;
            last_bits[k] = '0;
            prev_bits[k] = '0;
            last_err[k]  = 1'b0;
            rx_cnt[k]    = 0;
            aborts[k]    = 0;
        end
        test_reset();
        test_basic_even();
        test_parity_modes();
        test_inject();
        test_back_to_back();
        test_reset_midframe();
        test_wrap_random();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule
